// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the imem boot loader
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in, imem write port out
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data;
    logic                  mem_wren;

    // host side: drives the byte stream, observes the imem write port
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_address,
        input  mem_data,
        input  mem_wren
    );

    // loader side: consumes the byte stream, drives the imem write port
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_address,
        output mem_data,
        output mem_wren
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// rtl/imem_boot_loader_word_packer.sv - 8-to-32 bit MSB-first shift register
module imem_boot_loader_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0]  count_q;
    logic [31:0] word_q;

    // The byte being shifted now is the last of the word; the FSM uses this to leave DATA.
    assign word_full = shift_en && (count_q == 2'(BYTES_PER_WORD - 1));
    assign word      = word_q;

    // Shift bytes in from the low end so the first byte lands in the MSB.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            word_q  <= 32'd0;
        end else if (clear) begin
            count_q <= 2'd0;
            word_q  <= 32'd0;
        end else if (shift_en) begin
            count_q <= count_q + 2'd1;
            word_q  <= {word_q[23:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte stream to imem writer holding the CPU until verified
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    imem_boot_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        error
);
    // Largest legal image in words; 17 bits so a full 16-bit address space still fits.
    localparam logic [16:0]           MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic                  started_q;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            xor_q, xor_d;
    logic [1:0]            error_q, error_d;

    logic                  accept_state;
    logic                  in_ready;
    logic                  xfer;
    logic                  shift_en;
    logic                  pk_clear;
    logic                  word_full;
    logic [31:0]           packed_word;
    logic [15:0]           len_word;

    assign accept_state = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                          (state_q == DATA)   || (state_q == CSUM);
    // started_q keeps in_ready low until the first clock after reset; a byte
    // offered alongside restart is refused rather than silently dropped.
    assign in_ready     = started_q && accept_state && !restart;
    assign xfer         = bus.in_valid && in_ready;
    assign len_word     = {len_hi_q, bus.in_data};

    assign bus.in_ready    = in_ready;
    assign bus.mem_wren    = (state_q == WRITE);
    assign bus.mem_address = addr_q;
    assign bus.mem_data    = packed_word;
    assign done            = (state_q == DONE);
    assign cpu_hold        = (state_q != DONE);
    assign error           = error_q;

    imem_boot_loader_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (pk_clear),
        .byte_in   (bus.in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    // Next-state and datapath updates; restart overrides whatever the state decided.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        xor_d       = xor_q;
        error_d     = error_q;
        shift_en    = 1'b0;
        pk_clear    = 1'b0;

        case (state_q)
            LEN_HI: begin
                xor_d    = 8'd0;
                pk_clear = 1'b1;
                if (xfer) begin
                    len_hi_d = bus.in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    remaining_d = len_word;
                    if (len_word == 16'd0) begin
                        state_d = CSUM;
                    end else if ({1'b0, len_word} > MAX_WORDS) begin
                        state_d = ERR;
                        error_d = ERR_LEN;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shift_en = 1'b1;
                    xor_d    = xor_q ^ bus.in_data;
                    if (word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q > 16'd1) ? DATA : CSUM;
            end
            CSUM: begin
                if (xfer) begin
                    if (bus.in_data == xor_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        error_d = ERR_CSUM;
                    end
                end
            end
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = LEN_HI;
        endcase

        if (restart) begin
            state_d     = LEN_HI;
            remaining_d = 16'd0;
            addr_d      = BASE;
            xor_d       = 8'd0;
            error_d     = ERR_NONE;
            shift_en    = 1'b0;
            pk_clear    = 1'b1;
        end
    end

    // State and datapath registers; reset returns everything to the idle, held-CPU values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= LEN_HI;
            started_q   <= 1'b0;
            len_hi_q    <= 8'd0;
            remaining_q <= 16'd0;
            addr_q      <= BASE;
            xor_q       <= 8'd0;
            error_q     <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            started_q   <= 1'b1;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            xor_q       <= xor_d;
            error_q     <= error_d;
        end
    end

endmodule
